// File: rtl/spi_exe_master.sv
// spi_exe_master: initiator side of the serial execution-unit link.
// Serialises {A, B, OPER, 4'b0} MSB-first on MOSI under an active-low chip
// select. After a programmable gap it captures an RX_BITS-wide response
// frame from MISO. Result and flags are then presented with a one-cycle
// done pulse.
//
// Output timing: every output comes straight from a flop.
// - o_busy and o_cs follow the next state, so they change on the accepting
//   edge and on the edge that re-enters IDLE.
// - o_done and the result registers load on the edge that leaves DONE.
// - o_cs therefore rises together with o_done. Back-to-back frames get
//   exactly one CS-high cycle between them.
// - o_mosi is the MSB of the TX shift register. Zeros are shifted in, so
//   after the 24th shift the line reads 0 without any extra gating.

module spi_exe_master #(
  parameter int GAP_CYCLES = 2,
  parameter int RX_BITS    = 28
) (
  input  logic       i_sclk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_argA,
  input  logic [7:0] i_argB,
  input  logic [3:0] i_oper,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic [3:0] o_flags,
  output logic       o_cs,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam int TX_BITS  = 24;
  localparam int LEN_TR   = (RX_BITS > TX_BITS) ? RX_BITS : TX_BITS;
  localparam int LEN_MAX  = (GAP_CYCLES > LEN_TR) ? GAP_CYCLES : LEN_TR;
  localparam int CNT_W    = $clog2(LEN_MAX + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [CNT_W-1:0] TX_LAST_C  = CNT_W'(TX_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(GAP_LAST);
  localparam logic [CNT_W-1:0] RX_LAST_C  = CNT_W'(RX_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [TX_BITS-1:0]   tx_r;
  logic [RX_BITS-1:0]   rx_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 cs_r;
  logic [7:0]           result_r;
  logic [3:0]           flags_r;

  logic                 load_s;
  logic                 tx_shift_s;
  logic                 rx_shift_s;
  logic                 cnt_clr_s;
  logic                 cnt_inc_s;

  // Next-state decode and per-state datapath controls.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    tx_shift_s  = 1'b0;
    rx_shift_s  = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_SEND;
          load_s      = 1'b1;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        tx_shift_s = 1'b1;
        if (cnt_r == TX_LAST_C) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = (GAP_CYCLES == 0) ? ST_RECV : ST_GAP;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST_C) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = ST_RECV;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_RECV: begin
        rx_shift_s = 1'b1;
        if (cnt_r == RX_LAST_C) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_DONE: begin
        cnt_clr_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        cnt_clr_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shared bit/gap counter, cleared at every phase boundary.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_r <= '0;
    end else if (cnt_clr_s) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // TX shift register: operands captured once on the accepting edge, zeros shifted in.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      tx_r <= '0;
    end else if (load_s) begin
      tx_r <= {i_argA, i_argB, i_oper, 4'b0000};
    end else if (tx_shift_s) begin
      tx_r <= {tx_r[TX_BITS-2:0], 1'b0};
    end else begin
      tx_r <= tx_r;
    end
  end

  // RX shift register: MISO enters at the LSB, so the first bit ends up at the MSB.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      rx_r <= '0;
    end else if (rx_shift_s) begin
      rx_r <= {rx_r[RX_BITS-2:0], i_miso};
    end else begin
      rx_r <= rx_r;
    end
  end

  // Link control outputs: busy and chip select track the next state.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      busy_r <= 1'b0;
      cs_r   <= 1'b1;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      cs_r   <= (state_nxt_s == ST_IDLE);
    end
  end

  // Result capture and done pulse; result/flags hold until the next frame completes.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      done_r   <= 1'b0;
      result_r <= 8'h00;
      flags_r  <= 4'h0;
    end else if (state_r == ST_DONE) begin
      done_r   <= 1'b1;
      result_r <= rx_r[RX_BITS-1 -: 8];
      flags_r  <= rx_r[RX_BITS-9 -: 4];
    end else begin
      done_r   <= 1'b0;
      result_r <= result_r;
      flags_r  <= flags_r;
    end
  end

  assign o_busy   = busy_r;
  assign o_done   = done_r;
  assign o_result = result_r;
  assign o_flags  = flags_r;
  assign o_cs     = cs_r;
  assign o_mosi   = tx_r[TX_BITS-1];

endmodule

// File: tb/tb_spi_exe_master.sv
// Self-checking bench for spi_exe_master.
// Two instances: dut uses GAP_CYCLES=2 and dut0 uses GAP_CYCLES=0.
// Expected result/flags go into a queue at stimulus time and are popped on o_done.
// The slave model drives MISO from the accepting edge; outside the sample window it drives noise.

module tb_spi_exe_master;

  localparam int RXB = 28;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start0;
  logic [7:0] arga, argb;
  logic [3:0] oper;
  logic       miso;

  logic       busy, done, cs, mosi;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy0, done0, cs0, mosi0;
  logic [7:0] result0;
  logic [3:0] flags0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] sb_q[$];
  bit sel0 = 1'b0;

  wire       obs_busy   = sel0 ? busy0   : busy;
  wire       obs_done   = sel0 ? done0   : done;
  wire       obs_cs     = sel0 ? cs0     : cs;
  wire       obs_mosi   = sel0 ? mosi0   : mosi;
  wire [7:0] obs_result = sel0 ? result0 : result;
  wire [3:0] obs_flags  = sel0 ? flags0  : flags;

  always #5 clk = ~clk;

  spi_exe_master #(.GAP_CYCLES(2), .RX_BITS(RXB)) dut (
    .i_sclk(clk), .i_rst(rst_n), .i_start(start),
    .i_argA(arga), .i_argB(argb), .i_oper(oper),
    .o_busy(busy), .o_done(done), .o_result(result), .o_flags(flags),
    .o_cs(cs), .o_mosi(mosi), .i_miso(miso)
  );

  spi_exe_master #(.GAP_CYCLES(0), .RX_BITS(RXB)) dut0 (
    .i_sclk(clk), .i_rst(rst_n), .i_start(start0),
    .i_argA(arga), .i_argB(argb), .i_oper(oper),
    .o_busy(busy0), .o_done(done0), .o_result(result0), .o_flags(flags0),
    .o_cs(cs0), .o_mosi(mosi0), .i_miso(miso)
  );

  // One full frame on the selected instance.
  // t counts negedges after accept edge k. The done pulse is expected at t == 25+G+RXB.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                           input logic [7:0] res, input logic [3:0] flg, input logic [15:0] pad,
                           input bit disturb, input bit hold, input string name);
    int g = sel0 ? 0 : 2;
    int tend = 25 + g + RXB;
    int ndone = 0;
    int tdone = -1;
    int ctl_err = 0;
    int j;
    logic [RXB-1:0] rsp;
    logic [23:0] cap = '0;
    logic [23:0] exp_tx;
    logic [11:0] exp_r;
    rsp = {res, flg, pad};
    exp_tx = {a, b, op, 4'b0000};
    arga = a; argb = b; oper = op;
    if (sel0) start0 = 1'b1; else start = 1'b1;
    sb_q.push_back({res, flg});
    @(posedge clk);
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      if (t == 0 && !hold) begin start = 1'b0; start0 = 1'b0; end
      if (disturb && t == 5) begin
        arga = 8'($urandom); argb = 8'($urandom); oper = 4'($urandom);
        if (sel0) start0 = 1'b1; else start = 1'b1;
      end
      if (disturb && t == 6) begin start = 1'b0; start0 = 1'b0; end
      if (t < 24) cap = {cap[22:0], obs_mosi};
      else if (obs_mosi !== 1'b0) ctl_err++;
      if (t < tend - 1 && obs_cs !== 1'b0) ctl_err++;
      if (t == tend && obs_cs !== 1'b1) ctl_err++;
      if (obs_busy !== ((t < tend) ? 1'b1 : 1'b0)) ctl_err++;
      if (obs_done === 1'b1) begin
        ndone++;
        tdone = t;
        if (sb_q.size() > 0) begin
          exp_r = sb_q.pop_front();
          n_cmp++;
          if (obs_result !== exp_r[11:4]) begin
            n_bad++;
            $display("FAIL %s result: got %h expected %h", name, obs_result, exp_r[11:4]);
          end
          n_cmp++;
          if (obs_flags !== exp_r[3:0]) begin
            n_bad++;
            $display("FAIL %s flags: got %h expected %h", name, obs_flags, exp_r[3:0]);
          end
        end
      end
      j = t + 1 - (25 + g);
      if (j >= 0 && j < RXB) miso = rsp[RXB-1-j];
      else miso = 1'($urandom);
    end
    n_cmp++;
    if (cap !== exp_tx) begin
      n_bad++;
      $display("FAIL %s mosi_frame: got %h expected %h", name, cap, exp_tx);
    end
    n_cmp++;
    if (ndone != 1) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d expected 1", name, ndone);
    end
    n_cmp++;
    if (tdone != tend) begin
      n_bad++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, tdone, tend);
    end
    n_cmp++;
    if (ctl_err != 0) begin
      n_bad++;
      $display("FAIL %s cs_busy_mosi: got %0d bad cycles expected 0", name, ctl_err);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s scoreboard: got %0d pending expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; miso = 1'b0;
    arga = 8'h00; argb = 8'h00; oper = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cs, mosi, busy, done, result, flags} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got cs=%b mosi=%b busy=%b done=%b res=%h flg=%h expected 1 0 0 0 00 0",
               cs, mosi, busy, done, result, flags);
    end
    n_cmp++;
    if ({cs0, busy0, done0} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_state_g0: got %b expected 100", {cs0, busy0, done0});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel0 = 1'b0;
    run_frame(8'h12, 8'h34, 4'h5, 8'hA5, 4'b1001, 16'h0000, 1'b0, 1'b0, "basic");
    @(negedge clk);
  endtask

  task automatic test_latency();
    sel0 = 1'b0;
    run_frame(8'h01, 8'hFE, 4'hC, 8'h80, 4'h0, 16'h0000, 1'b0, 1'b0, "latency_g2");
    @(negedge clk);
    sel0 = 1'b1;
    run_frame(8'hC3, 8'h3C, 4'h7, 8'h80, 4'h0, 16'h0000, 1'b0, 1'b0, "latency_g0");
    run_frame(8'h5A, 8'h96, 4'h2, 8'h3D, 4'hE, 16'($urandom), 1'b0, 1'b0, "data_g0");
    @(negedge clk);
    sel0 = 1'b0;
  endtask

  task automatic test_start_busy();
    sel0 = 1'b0;
    run_frame(8'hDE, 8'hAD, 4'hB, 8'h5E, 4'h6, 16'($urandom), 1'b1, 1'b0, "start_busy");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    sel0 = 1'b0;
    arga = 8'hF0; argb = 8'h0F; oper = 4'h9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cs, mosi, busy, done, result, flags} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: got cs=%b mosi=%b busy=%b done=%b res=%h flg=%h expected 1 0 0 0 00 0",
               cs, mosi, busy, done, result, flags);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || cs !== 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d bad cycles expected 0", extra);
    end
    run_frame(8'h77, 8'h88, 4'h3, 8'hC6, 4'h5, 16'($urandom), 1'b0, 1'b0, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sel0 = 1'b0;
    run_frame(8'hAA, 8'h55, 4'h1, 8'h19, 4'h2, 16'($urandom), 1'b0, 1'b1, "b2b_first");
    run_frame(8'h33, 8'hCC, 4'hF, 8'hE7, 4'hB, 16'($urandom), 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_output_hold();
    int bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      miso = 1'($urandom); arga = 8'($urandom); argb = 8'($urandom); oper = 4'($urandom);
      if (result !== 8'hE7 || flags !== 4'hB || cs !== 1'b1 || mosi !== 1'b0 || done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL output_hold: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_output_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
